div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider used by the EX stage for DIV/DIVU.
- It is the requester side of the pipeline stall/flush interface: it raises the EX stall request while a divide is in progress.
- It obeys the controller's flush (annul) to abandon an in-flight divide.
- It returns {remainder, quotient} for the HI/LO write-back.

Parameters:
- WIDTH, 32, operand width. Result width is 2*WIDTH.
- ITER, 32, number of iterations. Must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- start_i  in  1  divide request from EX. Held high by EX until ready_o is seen.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU). Sampled with start_i in IDLE.
- opdata1_i  in  WIDTH  dividend. Sampled in IDLE.
- opdata2_i  in  WIDTH  divisor. Sampled in IDLE.
- annul_i  in  1  pipeline flush from controller. Aborts the current divide.
- result_o  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}.
- ready_o  out  1  result valid.
- stallreq_o  out  1  stall request to the controller's EX stall input.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, result_o=0, ready_o=0, counter=0. stallreq_o=0 while rst=0.
- States and transitions:
  - IDLE: if start_i=1 and annul_i=0:
    - divisor==0 -> BYZERO.
    - else -> ON. Latch |dividend| and |divisor| (absolute values only when signed_div_i=1), latch the sign bits, clear the counter.
  - BYZERO: next edge -> END with result=0.
  - ON: one shift-subtract iteration per edge. After the ITER-th iteration -> END. Quotient and remainder are sign-corrected on the END transition:
    - quotient is negated if the operand signs differ;
    - remainder takes the sign of the dividend.
  - END: ready_o=1, result_o valid. Stay in END while start_i=1. start_i=0 -> IDLE with ready_o=0 and result_o=0.
- Latency: start accepted at edge k -> iterations on edges k+1..k+32 -> ready_o=1 after edge k+32 (33 cycles). Divide-by-zero: ready_o=1 after edge k+1.
- stallreq_o (combinational) = start_i & ~annul_i & (state != END). It is high in the same cycle start_i first rises and drops in the cycle ready_o rises.
- In ON and BYZERO, start_i is ignored. Only annul_i or reset aborts.
- Annul: annul_i=1 in any state -> IDLE on the next edge, ready_o=0, result_o=0, no result produced. annul_i has priority over start_i in IDLE.
- Width rule: remainder arithmetic uses WIDTH+1 bits for the trial subtract.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Reset asserted mid-divide: immediate return to reset values. The stall drops and no partial result is visible.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if |dividend| < |divisor| (divisor nonzero), go directly to END with quotient=0 and remainder=dividend (original signed value). ready_o=1 after edge k+1, the same as divide-by-zero.
- Undefined: all nonzero-divisor divides take the full 33 cycles.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared include defines.v: state encodings (DivFree, DivByZero, DivOn, DivEnd), DivResultReady/NotReady, DivStart/DivStop, and the 64-bit result bus width define.
- Stop/NoStop are reused for stallreq_o.
- One natural sub-module: div_step, the combinational single iteration (shift, trial subtract, quotient bit). It is instantiated once inside div_unit.

Test Plan:
- Unsigned 100/7, start held -> stallreq_o=1 for 33 cycles, then ready_o=1 with result_o={0x00000002, 0x0000000E}. Drop start -> IDLE, ready_o=0.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- 5/0 -> ready_o=1 two cycles after start, result_o=0, stallreq_o=1 only in the first two cycles.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- annul_i pulsed at iteration 10 of 50/3 -> IDLE next cycle, ready_o never rises. Then 9/3 -> result {0, 3}.
- rst=0 at iteration 5 -> ready_o, result_o, stallreq_o at 0 before the next clock edge. After release, 7/7 completes with {0, 1}.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the radix-2 restoring divider (div_unit).
// State encodings, result-ready levels, start levels and stall request levels.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } divState_t;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic Stop              = 1'b1;
  localparam logic NoStop            = 1'b0;

endpackage

// File: rtl/div_step.sv
// One combinational iteration of the restoring divider.
// It shifts the next dividend bit into the partial remainder, then trial-subtracts the divisor.
// The quotient bit is 1 when the subtraction does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quot,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quot
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_trial;
  logic             w_qBit;

  // The compare runs on WIDTH+1 bits because the shifted remainder can exceed WIDTH bits.
  // When the compare succeeds, the difference is below the divisor, so WIDTH bits hold it exactly.
  always_comb begin
    w_shift = {i_rem, i_quot[WIDTH-1]};
    w_qBit  = (w_shift >= {1'b0, i_divisor});
    w_trial = w_shift[WIDTH-1:0] - i_divisor;
    o_rem   = w_qBit ? w_trial : w_shift[WIDTH-1:0];
    o_quot  = {i_quot[WIDTH-2:0], w_qBit};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// It requests an EX stall while a divide runs and abandons the divide on annul.
// It returns {remainder, quotient} for the HI/LO write-back.
// The optional macro DIV_EARLY_OUT_EN finishes in one cycle when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CntW = $clog2(ITER + 1);

  divState_t         r_state;
  logic [WIDTH-1:0]  r_rem;
  logic [WIDTH-1:0]  r_quot;
  logic [WIDTH-1:0]  r_divisor;
  logic [CntW-1:0]   r_cnt;
  logic              r_negQuot;
  logic              r_negRem;
  logic [2*WIDTH-1:0] r_result;
  logic              r_ready;

  logic [WIDTH-1:0]  w_absA;
  logic [WIDTH-1:0]  w_absB;
  logic [WIDTH-1:0]  w_stepRem;
  logic [WIDTH-1:0]  w_stepQuot;
  logic [WIDTH-1:0]  w_finalRem;
  logic [WIDTH-1:0]  w_finalQuot;

  // Operand magnitudes are taken only for signed divides; 0x80000000 maps onto itself, which is still correct unsigned.
  always_comb begin
    w_absA = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    w_absB = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quot    (r_quot),
    .i_divisor (r_divisor),
    .o_rem     (w_stepRem),
    .o_quot    (w_stepQuot)
  );

  // Sign correction of the last iteration's output: the quotient is negated when the signs differ.
  // The remainder follows the dividend's sign.
  always_comb begin
    w_finalQuot = r_negQuot ? (~w_stepQuot + 1'b1) : w_stepQuot;
    w_finalRem  = r_negRem  ? (~w_stepRem  + 1'b1) : w_stepRem;
  end

  // Stall EX while a request is pending and the result has not yet been presented; this is forced low during reset.
  assign stallreq_o = (rst && start_i && !annul_i && (r_state != DivEnd)) ? Stop : NoStop;

  assign result_o = r_result;
  assign ready_o  = r_ready;

  // Divider control FSM: accept in DivFree, iterate in DivOn, hold the result in DivEnd until start drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= DivFree;
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
      r_cnt     <= '0;
      r_negQuot <= 1'b0;
      r_negRem  <= 1'b0;
      r_result  <= '0;
      r_ready   <= DivResultNotReady;
    end else if (annul_i) begin
      r_state  <= DivFree;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      case (r_state)
        DivFree: begin
          if (start_i == DivStart) begin
            if (opdata2_i == '0) begin
              r_state <= DivByZero;
`ifdef DIV_EARLY_OUT_EN
            end else if (w_absA < w_absB) begin
              r_state  <= DivEnd;
              r_result <= {opdata1_i, {WIDTH{1'b0}}};
              r_ready  <= DivResultReady;
`endif
            end else begin
              r_state   <= DivOn;
              r_rem     <= '0;
              r_quot    <= w_absA;
              r_divisor <= w_absB;
              r_cnt     <= '0;
              r_negQuot <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              r_negRem  <= signed_div_i & opdata1_i[WIDTH-1];
            end
          end
        end
        DivByZero: begin
          r_state  <= DivEnd;
          r_result <= '0;
          r_ready  <= DivResultReady;
        end
        DivOn: begin
          r_rem  <= w_stepRem;
          r_quot <= w_stepQuot;
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == CntW'(ITER - 1)) begin
            r_state  <= DivEnd;
            r_result <= {w_finalRem, w_finalQuot};
            r_ready  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            r_state  <= DivFree;
            r_result <= '0;
            r_ready  <= DivResultNotReady;
          end
        end
        default: r_state <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit.
// A transaction-level model predicts ready/result/stall on every cycle.
// Directed divides also pin literal results and stall lengths.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_div_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

  // Model state: cycles left until the result appears, whether a result is showing, and the result itself.
  int          mCnt = 0;
  bit          mDone = 1'b0;
  logic [63:0] mRes = '0;

  div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  // The expected {remainder, quotient} uses plain 64-bit arithmetic, which truncates toward zero.
  function automatic logic [63:0] refDivide(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    if (b == 0) return 64'd0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // The number of clock edges from acceptance until the result is valid.
  function automatic int refLatency(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb;
    if (b == 0) return 1;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    if (sa < 0) sa = -sa;
    if (sb < 0) sb = -sb;
`ifdef DIV_EARLY_OUT_EN
    if (sa < sb) return 1;
`endif
    return 32;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Advance the model on clock edges and asynchronous reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mCnt = 0; mDone = 1'b0; mRes = '0;
    end else if (annul_i) begin
      mCnt = 0; mDone = 1'b0;
    end else if (mDone) begin
      if (!start_i) mDone = 1'b0;
    end else if (mCnt > 0) begin
      mCnt--;
      if (mCnt == 0) mDone = 1'b1;
    end else if (start_i) begin
      mRes = refDivide(opdata1_i, opdata2_i, signed_div_i);
      mCnt = refLatency(opdata1_i, opdata2_i, signed_div_i);
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("ready", {63'd0, ready_o}, {63'd0, mDone});
    checkOutput("result", result_o, mDone ? mRes : 64'd0);
    checkOutput("stall", {63'd0, stallreq_o}, {63'd0, rst & start_i & ~annul_i & ~mDone});
  end

  // Run one divide with start held until ready_o, then check the literal result and the number of stall cycles.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input logic [63:0] expRes, input int expStall, input string name);
    int stalls;
    bit got;
    @(negedge clk);
    #1;
    opdata1_i = a; opdata2_i = b; signed_div_i = sgn; start_i = 1'b1;
    #1;
    stalls = stallreq_o ? 1 : 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready_o) begin
        got = 1'b1;
        break;
      end
      if (stallreq_o) stalls++;
    end
    checkOutput({name, " completes"}, {63'd0, got}, 64'd1);
    if (got) begin
      checkOutput({name, " result"}, result_o, expRes);
      checkOutput({name, " stall cycles"}, 64'(stalls), 64'(expStall));
    end
    #1;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput({name, " ready drop"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    checkOutput("reset ready", {63'd0, ready_o}, 64'd0);
    checkOutput("reset result", result_o, 64'd0);
    checkOutput("reset stall", {63'd0, stallreq_o}, 64'd0);
    #1 rst = 1'b1;

    applyStimulus(32'd100, 32'd7, 1'b0, {32'h00000002, 32'h0000000E}, 33, "udiv 100/7");
    applyStimulus(32'hFFFFFFF9, 32'h00000002, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "sdiv -7/2");
    applyStimulus(32'd5, 32'd0, 1'b0, 64'd0, 2, "div 5/0");
    applyStimulus(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 33, "sdiv overflow");
    applyStimulus(32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, "sdiv 7/-2");

    // Annul a divide in flight; no result may ever appear.
    @(negedge clk);
    #1;
    opdata1_i = 32'd50; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    annul_i = 1'b1; start_i = 1'b0;
    @(negedge clk);
    #1 annul_i = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o) seen = 1'b1;
    end
    checkOutput("annul no ready", {63'd0, seen}, 64'd0);
    applyStimulus(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, "udiv 9/3");

    // Assert reset in the middle of a divide; the outputs must clear before the next edge.
    @(negedge clk);
    #1;
    opdata1_i = 32'd100; opdata2_i = 32'd7; signed_div_i = 1'b0; start_i = 1'b1;
    repeat (5) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midreset ready", {63'd0, ready_o}, 64'd0);
    checkOutput("midreset result", result_o, 64'd0);
    checkOutput("midreset stall", {63'd0, stallreq_o}, 64'd0);
    #1 start_i = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    applyStimulus(32'd7, 32'd7, 1'b0, {32'd0, 32'd1}, 33, "udiv 7/7");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
